lu_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the shared 16-bit logic unit.
//   - The logic unit performs AND/OR/XOR/XNOR/NAND/NOR/NOT/2's complement, selected by s1,s2,s3.

---
 rtl/lu_arbiter.sv | 73 +++++++
 tb/tb_lu_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lu_arbiter.sv
// lu_arbiter: two-requester round-robin arbiter and sequencer for the shared 16-bit logic unit
module lu_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       reqValid,
  output logic [1:0]       reqReady,
  input  logic [2:0]       reqOp0,
  input  logic [WIDTH-1:0] reqA0,
  input  logic [WIDTH-1:0] reqB0,
  input  logic [2:0]       reqOp1,
  input  logic [WIDTH-1:0] reqA1,
  input  logic [WIDTH-1:0] reqB1,
  output logic [WIDTH-1:0] luA,
  output logic [WIDTH-1:0] luB,
  output logic             luS1,
  output logic             luS2,
  output logic             luS3,
  input  logic [WIDTH-1:0] luOut,
  output logic [1:0]       rspValid,
  input  logic [1:0]       rspReady,
  output logic [WIDTH-1:0] rspData,
  output logic             busy,
  output logic [CNT_W-1:0] opCount
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic last, cur, g, take;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // On a tie the requester that was not served last wins
  always_comb begin
    g = &reqValid ? ~last : reqValid[1];
    take = state == IDLE && |reqValid;
    state_nxt = state == IDLE ? (take ? EXEC : IDLE) :
                state == EXEC ? RESP :
                state == RESP ? (rspReady[cur] ? IDLE : RESP) : IDLE;
  end
  always_comb begin
    reqReady = take ? (g ? 2'b10 : 2'b01) : 2'b00;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      luA <= '0;
      luB <= '0;
      {luS1, luS2, luS3} <= 3'b000;
      cur <= 1'b0;
      last <= 1'b1;
      rspData <= '0;
      rspValid <= 2'b00;
      opCount <= '0;
    end else begin
      if (take) begin
        luA <= g ? reqA1 : reqA0;
        luB <= g ? reqB1 : reqB0;
        {luS1, luS2, luS3} <= g ? reqOp1 : reqOp0;
        cur <= g;
      end
      if (state == EXEC) begin
        rspData <= luOut;
        rspValid <= cur ? 2'b10 : 2'b01;
      end
      if (state == RESP && rspReady[cur]) begin
        rspValid <= 2'b00;
        opCount <= opCount + CNT_W'(1);
        last <= cur;
      end
    end
endmodule

// File: tb/tb_lu_arbiter.sv
// tb_lu_arbiter: directed vector bench for lu_arbiter with a behavioural logic unit
module tb_lu_arbiter;
  logic clk = 0, reset_n = 1;
  logic [1:0] reqValid = 0, rspReady = 0;
  logic [2:0] reqOp0 = 0, reqOp1 = 0;
  logic [15:0] reqA0 = 0, reqB0 = 0, reqA1 = 0, reqB1 = 0;
  logic [1:0] reqReady, rspValid, reqReady2, rspValid2;
  logic [15:0] luA, luB, luOut, rspData, luA2, luB2, rspData2;
  logic luS1, luS2, luS3, busy, luS12, luS22, luS32, busy2;
  logic [15:0] opCount;
  logic [2:0] opCount2;
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  lu_arbiter dut (.clk(clk), .reset_n(reset_n), .reqValid(reqValid), .reqReady(reqReady),
    .reqOp0(reqOp0), .reqA0(reqA0), .reqB0(reqB0), .reqOp1(reqOp1), .reqA1(reqA1), .reqB1(reqB1),
    .luA(luA), .luB(luB), .luS1(luS1), .luS2(luS2), .luS3(luS3), .luOut(luOut),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .busy(busy), .opCount(opCount));
  // Narrow-counter copy sharing all stimulus, used to observe counter wrap
  lu_arbiter #(.WIDTH(16), .CNT_W(3)) dut2 (.clk(clk), .reset_n(reset_n), .reqValid(reqValid),
    .reqReady(reqReady2), .reqOp0(reqOp0), .reqA0(reqA0), .reqB0(reqB0), .reqOp1(reqOp1),
    .reqA1(reqA1), .reqB1(reqB1), .luA(luA2), .luB(luB2), .luS1(luS12), .luS2(luS22), .luS3(luS32),
    .luOut(luOut), .rspValid(rspValid2), .rspReady(rspReady), .rspData(rspData2), .busy(busy2),
    .opCount(opCount2));
  always_comb
    case ({luS1, luS2, luS3})
      3'b000: luOut = luA & luB;
      3'b001: luOut = luA | luB;
      3'b010: luOut = luA ^ luB;
      3'b011: luOut = ~(luA ^ luB);
      3'b100: luOut = ~(luA & luB);
      3'b101: luOut = ~(luA | luB);
      3'b110: luOut = ~luA;
      default: luOut = -luA;
    endcase
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  typedef struct {logic r; logic [2:0] op; logic [15:0] a, b, exp;} vec_t;
  vec_t tv[8];
  initial begin
    tv[0] = '{1'b0, 3'b000, 16'hFCC3, 16'hCFCC, 16'hCCC0};
    tv[1] = '{1'b1, 3'b001, 16'hFCC3, 16'hCFCC, 16'hFFCF};
    tv[2] = '{1'b1, 3'b010, 16'hFCC3, 16'hCFCC, 16'h330F};
    tv[3] = '{1'b0, 3'b011, 16'hFCC3, 16'hCFCC, 16'hCCF0};
    tv[4] = '{1'b0, 3'b100, 16'hFCC3, 16'hCFCC, 16'h333F};
    tv[5] = '{1'b1, 3'b101, 16'hFCC3, 16'hCFCC, 16'h0030};
    tv[6] = '{1'b0, 3'b110, 16'hFCC3, 16'hCFCC, 16'h033C};
    tv[7] = '{1'b1, 3'b111, 16'hFCC3, 16'hCFCC, 16'h033D};
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", reqReady, 0);
    check("rst_rsp_valid", rspValid, 0);
    check("rst_rsp_data", rspData, 0);
    check("rst_lu", {luA, luB, luS1, luS2, luS3}, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", opCount, 0);
    reset_n = 1;
    rspReady = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tv[i].r) begin reqOp1 = tv[i].op; reqA1 = tv[i].a; reqB1 = tv[i].b; end
      else begin reqOp0 = tv[i].op; reqA0 = tv[i].a; reqB0 = tv[i].b; end
      reqValid = tv[i].r ? 2'b10 : 2'b01;
      #1 check("req_ready", reqReady, tv[i].r ? 2 : 1);
      @(negedge clk);
      reqValid = 0;
      check("lu_a", luA, tv[i].a);
      check("lu_b", luB, tv[i].b);
      check("lu_s", {luS1, luS2, luS3}, tv[i].op);
      check("exec_busy", busy, 1);
      check("exec_rsp_valid", rspValid, 0);
      @(negedge clk);
      check("rsp_valid", rspValid, tv[i].r ? 2 : 1);
      check("rsp_data", rspData, tv[i].exp);
      @(negedge clk);
      check("rsp_done", rspValid, 0);
      check("op_count", opCount, i + 1);
      check("op_count_wrap", opCount2, (i + 1) % 8);
    end
    // Round-robin with both requesters held from reset
    reset_n = 0;
    reqOp0 = 3'b110; reqA0 = 16'h00FF; reqB0 = 0;
    reqOp1 = 3'b111; reqA1 = 16'h0001; reqB1 = 0;
    reqValid = 2'b11;
    @(negedge clk);
    reset_n = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_grant", reqReady, k % 2 ? 2 : 1);
      @(negedge clk);
      @(negedge clk);
      check("rr_rsp_valid", rspValid, k % 2 ? 2 : 1);
      check("rr_rsp_data", rspData, k % 2 ? 16'hFFFF : 16'hFF00);
      @(negedge clk);
    end
    // Backpressured response blocks the other requester
    reqOp0 = 3'b000; reqA0 = 16'hFCC3; reqB0 = 16'hCFCC;
    rspReady = 0;
    #1 check("bp_grant", reqReady, 1);
    @(negedge clk);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      check("bp_rsp_valid", rspValid, 1);
      check("bp_rsp_data", rspData, 16'hCCC0);
      check("bp_busy", busy, 1);
      check("bp_req_ready", reqReady, 0);
      @(negedge clk);
    end
    rspReady = 2'b10;
    @(negedge clk);
    check("bp_wrong_ready", rspValid, 1);
    rspReady = 2'b01;
    @(negedge clk);
    check("bp_next_grant", reqReady, 2);
    check("bp_op_count", opCount, 5);
    reqValid = 0;
    rspReady = 2'b11;
    // Reset in the middle of an operation
    @(negedge clk);
    reqValid = 2'b01;
    @(negedge clk);
    reqValid = 0;
    check("mid_busy_pre", busy, 1);
    reset_n = 0;
    #1;
    check("mid_rsp_valid", rspValid, 0);
    check("mid_lu", {luA, luB, luS1, luS2, luS3}, 0);
    check("mid_busy", busy, 0);
    check("mid_op_count", opCount, 0);
    check("mid_op_count2", opCount2, 0);
    check("mid_rsp_data", rspData, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("mid_no_rsp", rspValid, 0);
    reqOp1 = 3'b001; reqA1 = 16'hFCC3; reqB1 = 16'hCFCC;
    reqValid = 2'b10;
    #1 check("mid_new_grant", reqReady, 2);
    @(negedge clk);
    reqValid = 0;
    @(negedge clk);
    check("mid_new_rsp_valid", rspValid, 2);
    check("mid_new_rsp_data", rspData, 16'hFFCF);
    @(negedge clk);
    check("mid_new_op_count", opCount, 1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
